// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR AXI burst initiator: FSM states,
// address/data width derivation and the burst data pattern.
package ddr_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    // Widest data bus supported (DQ_LEVEL up to 3).
    localparam int MAX_DW = 64;

    function automatic int axi_aw(input int ba_bits, input int row_bits,
                                  input int col_bits, input int dq_level);
        return ba_bits + row_bits + col_bits + dq_level - 1;
    endfunction

    function automatic int axi_dw(input int dq_level);
        return 8 << dq_level;
    endfunction

    // Beat data is the seed plus the beat index; callers truncate to their width.
    function automatic logic [MAX_DW-1:0] pat(input logic [MAX_DW-1:0] seed,
                                              input logic [7:0] beat);
        return seed + MAX_DW'(beat);
    endfunction

endpackage

// File: rtl/ddr_axi_initiator_if.sv
// AXI-style write/read channels between the burst initiator and the
// DDR controller slave port.
interface ddr_axi_initiator_if #(
    parameter int AW = 26,
    parameter int DW = 16
) ();
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid;
    logic          wready;
    logic          wlast;
    logic [DW-1:0] wdata;
    logic          bvalid;
    logic          bready;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic [DW-1:0] rdata;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
               arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rvalid, rlast, rdata
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
               arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rvalid, rlast, rdata
    );
endinterface

// File: rtl/ddr_axi_watchdog.sv
// Cycle watchdog: counts while not cleared and flags expiry once the
// count reaches TIMEOUT.
module ddr_axi_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic expire
);
    logic [31:0] cnt;

    // Count idle-handshake cycles; any clear restarts from zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign expire = (cnt >= 32'(TIMEOUT));
endmodule

// File: rtl/ddr_axi_initiator.sv
// Burst traffic initiator: writes an incrementing pattern or reads it
// back and counts mismatches. Every output is a register.
module ddr_axi_initiator
    import ddr_axi_pkg::*;
#(
    parameter int BA_BITS  = 2,
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 11,
    parameter int DQ_LEVEL = 1,
    parameter int TIMEOUT  = 65535,
    localparam int AW = axi_aw(BA_BITS, ROW_BITS, COL_BITS, DQ_LEVEL),
    localparam int DW = axi_dw(DQ_LEVEL)
) (
    input  logic          core_clk,
    input  logic          core_rstn_sync,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_len,
    input  logic [DW-1:0] cmd_seed,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   err_cnt,
    ddr_axi_initiator_if.master bus
);
    state_t        state, state_n;
    logic [7:0]    beat, beat_n, beat_inc, len, len_n;
    logic [DW-1:0] seed, seed_n;
    logic          cmd_ready_n, done_n, timeout_n;
    logic [15:0]   err_cnt_n;
    logic          awvalid_n, wvalid_n, wlast_n, bready_n, arvalid_n, rready_n;
    logic [AW-1:0] awaddr_n, araddr_n;
    logic [7:0]    awlen_n, arlen_n;
    logic [DW-1:0] wdata_n;
    logic          accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic          mismatch, wd_clear, wd_expire, abort;

    function automatic logic [DW-1:0] pat_dw(input logic [DW-1:0] s, input logic [7:0] b);
        logic [MAX_DW-1:0] full;
        full = pat(MAX_DW'(s), b);
        return full[DW-1:0];
    endfunction

    assign accept   = cmd_valid & cmd_ready;
    assign aw_hs    = bus.awvalid & bus.awready;
    assign w_hs     = bus.wvalid & bus.wready;
    assign b_hs     = bus.bready & bus.bvalid;
    assign ar_hs    = bus.arvalid & bus.arready;
    assign r_hs     = bus.rready & bus.rvalid;
    assign any_hs   = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign beat_inc = beat + 8'd1;
    assign mismatch = (bus.rdata != pat_dw(seed, beat)) || (bus.rlast != (beat == len));
    assign wd_clear = (state == IDLE) | any_hs;
    // A handshake in the expiry cycle wins over the watchdog.
    assign abort    = wd_expire & ~any_hs & (state != IDLE);

    ddr_axi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (core_clk),
        .rstn   (core_rstn_sync),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_n     = state;
        beat_n      = beat;
        len_n       = len;
        seed_n      = seed;
        cmd_ready_n = 1'b0;
        done_n      = 1'b0;
        timeout_n   = timeout;
        err_cnt_n   = err_cnt;
        awvalid_n   = 1'b0;
        awaddr_n    = bus.awaddr;
        awlen_n     = bus.awlen;
        wvalid_n    = 1'b0;
        wlast_n     = bus.wlast;
        wdata_n     = bus.wdata;
        bready_n    = 1'b0;
        arvalid_n   = 1'b0;
        araddr_n    = bus.araddr;
        arlen_n     = bus.arlen;
        rready_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    len_n     = cmd_len;
                    seed_n    = cmd_seed;
                    beat_n    = 8'd0;
                    timeout_n = 1'b0;
                    if (cmd_write) begin
                        state_n   = WADDR;
                        awvalid_n = 1'b1;
                        awaddr_n  = cmd_addr;
                        awlen_n   = cmd_len;
                    end else begin
                        state_n   = RADDR;
                        arvalid_n = 1'b1;
                        araddr_n  = cmd_addr;
                        arlen_n   = cmd_len;
                        err_cnt_n = 16'd0;
                    end
                end else begin
                    cmd_ready_n = 1'b1;
                end
            end
            WADDR: begin
                if (aw_hs) begin
                    state_n  = WDATA;
                    wvalid_n = 1'b1;
                    wdata_n  = pat_dw(seed, 8'd0);
                    wlast_n  = (len == 8'd0);
                end else begin
                    awvalid_n = 1'b1;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    beat_n = beat_inc;
                    if (bus.wlast) begin
                        state_n  = WRESP;
                        wlast_n  = 1'b0;
                        bready_n = 1'b1;
                    end else begin
                        wvalid_n = 1'b1;
                        wdata_n  = pat_dw(seed, beat_inc);
                        wlast_n  = (beat_inc == len);
                    end
                end else begin
                    wvalid_n = 1'b1;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    cmd_ready_n = 1'b1;
                end else begin
                    bready_n = 1'b1;
                end
            end
            RADDR: begin
                if (ar_hs) begin
                    state_n  = RDATA;
                    rready_n = 1'b1;
                end else begin
                    arvalid_n = 1'b1;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    if (mismatch && err_cnt != 16'hFFFF) begin
                        err_cnt_n = err_cnt + 16'd1;
                    end
                    // Completion is by beat count; a missing rlast is only an error.
                    if (beat == len) begin
                        state_n     = IDLE;
                        done_n      = 1'b1;
                        cmd_ready_n = 1'b1;
                    end else begin
                        beat_n   = beat_inc;
                        rready_n = 1'b1;
                    end
                end else begin
                    rready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n     = IDLE;
            done_n      = 1'b1;
            timeout_n   = 1'b1;
            cmd_ready_n = 1'b1;
            awvalid_n   = 1'b0;
            wvalid_n    = 1'b0;
            wlast_n     = 1'b0;
            bready_n    = 1'b0;
            arvalid_n   = 1'b0;
            rready_n    = 1'b0;
        end
    end

    // State, burst context and output registers.
    always_ff @(posedge core_clk) begin
        if (!core_rstn_sync) begin
            state       <= IDLE;
            beat        <= 8'd0;
            len         <= 8'd0;
            seed        <= '0;
            cmd_ready   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= 16'd0;
            bus.awvalid <= 1'b0;
            bus.awaddr  <= '0;
            bus.awlen   <= 8'd0;
            bus.wvalid  <= 1'b0;
            bus.wlast   <= 1'b0;
            bus.wdata   <= '0;
            bus.bready  <= 1'b0;
            bus.arvalid <= 1'b0;
            bus.araddr  <= '0;
            bus.arlen   <= 8'd0;
            bus.rready  <= 1'b0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            len         <= len_n;
            seed        <= seed_n;
            cmd_ready   <= cmd_ready_n;
            done        <= done_n;
            timeout     <= timeout_n;
            err_cnt     <= err_cnt_n;
            bus.awvalid <= awvalid_n;
            bus.awaddr  <= awaddr_n;
            bus.awlen   <= awlen_n;
            bus.wvalid  <= wvalid_n;
            bus.wlast   <= wlast_n;
            bus.wdata   <= wdata_n;
            bus.bready  <= bready_n;
            bus.arvalid <= arvalid_n;
            bus.araddr  <= araddr_n;
            bus.arlen   <= arlen_n;
            bus.rready  <= rready_n;
        end
    end
endmodule

// File: tb/tb_ddr_axi_initiator.sv
// Bench for ddr_axi_initiator: directed bring-up scenarios followed by
// randomized bursts, checked against a transaction-level model.
module tb_ddr_axi_initiator;
    localparam int BA_BITS  = 2;
    localparam int ROW_BITS = 13;
    localparam int COL_BITS = 11;
    localparam int DQ_LEVEL = 1;
    localparam int TIMEOUT  = 16;
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
    localparam int DW = 8 << DQ_LEVEL;

    logic          core_clk = 1'b0;
    logic          core_rstn_sync;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] cmd_seed;
    logic          done, timeout;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs and model state.
    int            cfg_mode;      // 0 all ready, 1 wready toggles, 2 random, 3 awready stuck low
    bit            cfg_noise;
    int            cfg_bad_beat;
    logic [DW-1:0] cfg_bad_data;
    int            cfg_early;
    int            stall_run = 0;
    logic [15:0]   exp_err = 16'd0;
    int            done_cyc, final_cyc, w_beats;

    ddr_axi_initiator_if #(.AW(AW), .DW(DW)) axi ();

    ddr_axi_initiator #(
        .BA_BITS (BA_BITS),
        .ROW_BITS(ROW_BITS),
        .COL_BITS(COL_BITS),
        .DQ_LEVEL(DQ_LEVEL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .core_clk      (core_clk),
        .core_rstn_sync(core_rstn_sync),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .done          (done),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .bus           (axi)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_slave();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rdata   = '0;
    endtask

    // Random ready/valid that never stalls long enough to trip the watchdog.
    function automatic bit slave_bit();
        bit b;
        b = ($urandom_range(0, 2) != 0) || (stall_run >= 3);
        stall_run = b ? 0 : stall_run + 1;
        return b;
    endfunction

    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [DW-1:0] seed, input bit exp_to);
        int            cyc, w_beat, r_beat, budget;
        int            first_wv, first_bv, first_rv, aw_hs_cyc, ar_hs_cyc, last_w_cyc;
        bit            got_done, rd, mis, prev_w_stall;
        logic [DW-1:0] exp_d, exp_w, prev_wdata;
        logic          prev_wlast;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_seed  = seed;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = 8'($urandom);
        cmd_seed  = DW'($urandom);
        if (!wr) exp_err = 16'd0;
        check("accept_cmd_ready_low", cmd_ready, 1'b0);
        check("accept_timeout_clear", timeout, 1'b0);
        check("accept_addr_valid", wr ? axi.awvalid : axi.arvalid, 1'b1);

        cyc = 1; w_beat = 0; r_beat = 0; got_done = 0; done_cyc = -1; final_cyc = -1;
        first_wv = -1; first_bv = -1; first_rv = -1; aw_hs_cyc = -1; ar_hs_cyc = -1;
        last_w_cyc = -1; prev_w_stall = 0; prev_wdata = '0; prev_wlast = 1'b0;
        while (!got_done && cyc < 3000) begin
            check("err_cnt", err_cnt, exp_err);
            if (done === 1'b1) begin
                got_done = 1;
                done_cyc = cyc;
                check("done_cmd_ready", cmd_ready, 1'b1);
                check("done_timeout", timeout, exp_to);
                check("done_valids_low", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'd0);
            end else begin
                if (axi.wvalid === 1'b1 && first_wv < 0) first_wv = cyc;
                if (axi.bready === 1'b1 && first_bv < 0) first_bv = cyc;
                if (axi.rready === 1'b1 && first_rv < 0) first_rv = cyc;
                if (prev_w_stall) begin
                    check("w_hold_data", axi.wdata, prev_wdata);
                    check("w_hold_last", axi.wlast, prev_wlast);
                end
                if (axi.awvalid === 1'b1) begin
                    check("awaddr", axi.awaddr, addr);
                    check("awlen", axi.awlen, len);
                end
                if (axi.arvalid === 1'b1) begin
                    check("araddr", axi.araddr, addr);
                    check("arlen", axi.arlen, len);
                end
                rd = slave_bit();
                axi.awready = (cfg_mode == 3) ? 1'b0 : (cfg_mode == 2) ? rd : 1'b1;
                axi.wready  = (cfg_mode == 1) ? (cyc % 2 == 0) : (cfg_mode == 2) ? rd : 1'b1;
                axi.bvalid  = (cfg_mode == 2) ? rd : 1'b1;
                axi.arready = (cfg_mode == 2) ? rd : 1'b1;
                axi.rvalid  = (cfg_mode == 2) ? rd : 1'b1;
                exp_d = seed + DW'(r_beat);
                axi.rdata = exp_d;
                axi.rlast = (r_beat == int'(len));
                if (cfg_bad_beat == r_beat) axi.rdata = cfg_bad_data;
                if (cfg_early == r_beat) axi.rlast = 1'b1;
                if (cfg_noise) begin
                    if ($urandom_range(0, 5) == 0) axi.rdata = axi.rdata ^ DW'($urandom_range(1, 255));
                    if ($urandom_range(0, 7) == 0) axi.rlast = ~axi.rlast;
                end
                if (axi.awvalid && axi.awready) aw_hs_cyc = cyc;
                if (axi.arvalid && axi.arready) ar_hs_cyc = cyc;
                if (axi.wvalid && axi.wready) begin
                    exp_w = seed + DW'(w_beat);
                    check("wdata", axi.wdata, exp_w);
                    check("wlast", axi.wlast, (w_beat == int'(len)));
                    if (axi.wlast) last_w_cyc = cyc;
                    w_beat++;
                end
                prev_w_stall = axi.wvalid && !axi.wready;
                prev_wdata   = axi.wdata;
                prev_wlast   = axi.wlast;
                if (axi.bvalid && axi.bready) final_cyc = cyc;
                if (axi.rvalid && axi.rready) begin
                    mis = (axi.rdata != exp_d) || (axi.rlast != (r_beat == int'(len)));
                    if (mis && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
                    if (r_beat == int'(len)) final_cyc = cyc;
                    r_beat++;
                end
                tick();
                cyc++;
            end
        end
        check("done_seen", got_done, 1'b1);
        w_beats = w_beat;
        if (exp_to) begin
            check("timeout_done_cycle", done_cyc, 1 + TIMEOUT + 1);
            check("timeout_no_beats", w_beat, 0);
        end else begin
            check("done_latency", done_cyc, final_cyc + 1);
            if (wr) begin
                check("w_after_aw", first_wv, aw_hs_cyc + 1);
                check("b_after_wlast", first_bv, last_w_cyc + 1);
                check("w_beat_count", w_beat, int'(len) + 1);
                if (cfg_mode == 0) check("w_rate", last_w_cyc - first_wv, int'(len));
            end else begin
                check("r_after_ar", first_rv, ar_hs_cyc + 1);
                check("r_beat_count", r_beat, int'(len) + 1);
            end
        end
        idle_slave();
        tick();
        check("post_done_low", done, 1'b0);
        check("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        bit seen;
        core_rstn_sync = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 8'd0; cmd_seed = '0;
        cfg_mode = 0; cfg_noise = 0; cfg_bad_beat = -1; cfg_bad_data = '0; cfg_early = -1;
        idle_slave();
        repeat (3) tick();

        // Reset values
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_err_cnt", err_cnt, 16'd0);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'd0);
        check("rst_payload", {axi.awaddr, axi.araddr, axi.awlen, axi.arlen, axi.wdata}, '0);
        core_rstn_sync = 1'b1;
        tick();
        check("rst_release_ready", cmd_ready, 1'b1);

        // Single-beat write
        run_cmd(1'b1, AW'('h100), 8'd0, DW'('hA5A5), 1'b0);
        check("single_write_done_cycle", done_cyc, 4);
        check("single_write_beats", w_beats, 1);

        // Back-pressured write
        cfg_mode = 1;
        run_cmd(1'b1, AW'('h2000), 8'd7, DW'('h0010), 1'b0);
        check("bp_write_beats", w_beats, 8);

        // Clean read
        cfg_mode = 0;
        run_cmd(1'b0, AW'('h40), 8'd3, DW'('h1000), 1'b0);
        check("clean_read_err", err_cnt, 16'd0);

        // Bad read: corrupt beat 2, early rlast on beat 1
        cfg_bad_beat = 2; cfg_bad_data = DW'('hFFFF); cfg_early = 1;
        run_cmd(1'b0, AW'('h80), 8'd3, DW'('h1000), 1'b0);
        check("bad_read_err", err_cnt, 16'd2);
        cfg_bad_beat = -1; cfg_early = -1;

        // Watchdog on a stuck AW channel
        cfg_mode = 3;
        run_cmd(1'b1, AW'('h300), 8'd3, DW'('h0005), 1'b1);
        check("timeout_sticky", timeout, 1'b1);

        // Next command clears the sticky timeout
        cfg_mode = 0;
        run_cmd(1'b1, AW'('h304), 8'd1, DW'('h0006), 1'b0);

        // Randomized bursts with back-pressure and read corruption
        cfg_mode = 2; cfg_noise = 1;
        for (int n = 0; n < 14; n++) begin
            run_cmd(1'($urandom), AW'($urandom), 8'($urandom_range(0, 12)), DW'($urandom), 1'b0);
        end

        // Longest bursts
        cfg_mode = 0; cfg_noise = 0;
        run_cmd(1'b1, AW'('h1000), 8'd255, DW'('hFF80), 1'b0);
        cfg_mode = 2; cfg_noise = 1;
        run_cmd(1'b0, AW'('h1000), 8'd255, DW'('hFF80), 1'b0);
        cfg_noise = 0;

        // Reset in the middle of a write burst, on beat 3 of 8
        cfg_mode = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'('h400); cmd_len = 8'd7; cmd_seed = DW'('h0200);
        tick();
        cmd_valid = 1'b0;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (axi.wvalid === 1'b1 && axi.wdata === DW'('h0203)) seen = 1;
            else tick();
        end
        check("rst_mid_reached_beat3", seen, 1'b1);
        core_rstn_sync = 1'b0;
        tick();
        exp_err = 16'd0;
        check("rst_mid_cmd_ready", cmd_ready, 1'b0);
        check("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, 6'd0);
        check("rst_mid_flags", {done, timeout, err_cnt}, 18'd0);
        check("rst_mid_payload", {axi.awaddr, axi.araddr, axi.awlen, axi.arlen, axi.wdata}, '0);
        core_rstn_sync = 1'b1;
        idle_slave();
        tick();
        check("rst_mid_release_ready", cmd_ready, 1'b1);
        check("rst_mid_release_wvalid", axi.wvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
